// File: rtl/instruction_fetch_if.sv
// Instruction memory port bundle between the fetch stage and a 16x16 registered-read memory.
interface instruction_fetch_if #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned INSTR_W = 16
);
  logic [ADDR_W-1:0]  addr;
  logic               wren;
  logic [INSTR_W-1:0] din;
  logic [INSTR_W-1:0] q;

  // Fetch stage drives the request side, memory returns q one cycle later.
  modport master (output addr, output wren, output din, input q);
  modport slave  (input addr, input wren, input din, output q);
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, absorbs the memory's one-cycle read latency and
// presents a registered IF/ID word, with decode stall (via a 1-entry skid)
// and branch redirect with flush.
module instruction_fetch #(
  parameter int unsigned       ADDR_W   = 4,
  parameter int unsigned       INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_i,
  input  logic                redirect_i,
  input  logic [ADDR_W-1:0]   redirect_addr_i,
  instruction_fetch_if.master imem,
  output logic [INSTR_W-1:0]  instr_o,
  output logic [ADDR_W-1:0]   instr_pc_o,
  output logic                instr_valid_o
);

  // BOOT: nothing in flight; RUN: word arriving on q; HOLD: skid buffer full.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               instr_valid_q, instr_valid_d;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      skid_instr_q  <= '0;
      skid_pc_q     <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Next-state: redirect beats stall; stall parks the arriving word in the skid.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    if (redirect_i) begin
      pc_d          = redirect_addr_i;
      state_d       = BOOT;
      instr_valid_d = 1'b0;
    end else if (stall_i) begin
      // Only a word actually in flight needs saving; PC holds so memory rereads.
      case (state_q)
        RUN: begin
          skid_instr_d = imem.q;
          skid_pc_d    = req_pc_q;
          state_d      = HOLD;
        end
        HOLD:    state_d = HOLD;
        default: state_d = BOOT;
      endcase
    end else begin
      if (state_q == HOLD) begin
        instr_d       = skid_instr_q;
        instr_pc_d    = skid_pc_q;
        instr_valid_d = 1'b1;
      end else begin
        instr_d       = imem.q;
        instr_pc_d    = req_pc_q;
        instr_valid_d = (state_q == RUN);
      end
      state_d  = RUN;
      req_pc_d = pc_q;
      pc_d     = pc_q + ADDR_W'(1);
    end
  end

  // The stage only reads memory; address comes straight from the PC register.
  assign imem.addr = pc_q;
  assign imem.wren = 1'b0;
  assign imem.din  = '0;

  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = instr_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a registered-read memory model.
module tb_instruction_fetch;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned INSTR_W = 16;

  logic              clk;
  logic              rst_n;
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;

  logic [INSTR_W-1:0] mem [16];

  int total;
  int bad;

  instruction_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) imem ();

  instruction_fetch #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .RESET_PC(4'd0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall),
    .redirect_i     (redirect),
    .redirect_addr_i(redirect_addr),
    .imem           (imem.master),
    .instr_o        (instr),
    .instr_pc_o     (instr_pc),
    .instr_valid_o  (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: q holds mem[address presented in the previous cycle].
  always @(posedge clk) begin
    imem.q <= mem[imem.addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] i, input logic [3:0] p);
    chk({tag, ".valid"}, 32'(instr_valid), 32'(v));
    if (v) begin
      chk({tag, ".instr"}, 32'(instr), 32'(i));
      chk({tag, ".pc"}, 32'(instr_pc), 32'(p));
    end
    chk({tag, ".wren"}, 32'(imem.wren), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    mem[0]  = 16'h40A0;
    mem[1]  = 16'h6000;
    mem[2]  = 16'h40A1;
    mem[3]  = 16'h60A2;
    mem[15] = 16'h1234;
    imem.q        = '0;
    rst_n         = 1'b0;
    stall         = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;

    // Reset for two edges
    step();
    step();
    chk("rst.valid", 32'(instr_valid), 32'd0);
    chk("rst.instr", 32'(instr), 32'd0);
    chk("rst.pc", 32'(instr_pc), 32'd0);
    chk("rst.addr", 32'(imem.addr), 32'd0);
    chk("rst.wren", 32'(imem.wren), 32'd0);
    chk("rst.din", 32'(imem.din), 32'd0);

    // Free run from reset
    rst_n = 1'b1;
    step();
    chk_out("boot.e1", 1'b0, 16'h0, 4'd0);
    chk("boot.e1.addr", 32'(imem.addr), 32'd1);
    step();
    chk_out("run.0", 1'b1, 16'h40A0, 4'd0);
    step();
    chk_out("run.1", 1'b1, 16'h6000, 4'd1);

    // Single-cycle stall while 6000/1 is presented
    stall = 1'b1;
    step();
    chk_out("st1.hold", 1'b1, 16'h6000, 4'd1);
    stall = 1'b0;
    step();
    chk_out("st1.2", 1'b1, 16'h40A1, 4'd2);
    step();
    chk_out("st1.3", 1'b1, 16'h60A2, 4'd3);

    // Redirect to 0, then a 3-cycle stall on 40A0/0
    redirect = 1'b1;
    redirect_addr = 4'd0;
    step();
    chk_out("rd0.a", 1'b0, 16'h0, 4'd0);
    redirect = 1'b0;
    step();
    chk_out("rd0.b", 1'b0, 16'h0, 4'd0);
    step();
    chk_out("rd0.0", 1'b1, 16'h40A0, 4'd0);
    chk("st3.addr0", 32'(imem.addr), 32'd2);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_out("st3.hold", 1'b1, 16'h40A0, 4'd0);
      chk("st3.addr", 32'(imem.addr), 32'd2);
    end
    stall = 1'b0;
    step();
    chk_out("st3.1", 1'b1, 16'h6000, 4'd1);
    step();
    chk_out("st3.2", 1'b1, 16'h40A1, 4'd2);

    // Redirect to 3 during run
    redirect = 1'b1;
    redirect_addr = 4'd3;
    step();
    chk_out("rd3.a", 1'b0, 16'h0, 4'd0);
    chk("rd3.addr", 32'(imem.addr), 32'd3);
    redirect = 1'b0;
    step();
    chk_out("rd3.b", 1'b0, 16'h0, 4'd0);
    step();
    chk_out("rd3.3", 1'b1, 16'h60A2, 4'd3);
    step();
    chk_out("rd3.4", 1'b1, 16'h0000, 4'd4);

    // Fill the skid, then redirect with stall in the same cycle
    stall = 1'b1;
    step();
    chk_out("rs.hold", 1'b1, 16'h0000, 4'd4);
    redirect = 1'b1;
    redirect_addr = 4'd3;
    step();
    chk_out("rs.a", 1'b0, 16'h0, 4'd0);
    redirect = 1'b0;
    stall = 1'b0;
    step();
    chk_out("rs.b", 1'b0, 16'h0, 4'd0);
    step();
    chk_out("rs.3", 1'b1, 16'h60A2, 4'd3);
    step();
    chk_out("rs.4", 1'b1, 16'h0000, 4'd4);

    // Redirect to 14 and wrap past 15
    redirect = 1'b1;
    redirect_addr = 4'd14;
    step();
    chk_out("wr.a", 1'b0, 16'h0, 4'd0);
    redirect = 1'b0;
    step();
    chk_out("wr.b", 1'b0, 16'h0, 4'd0);
    step();
    chk_out("wr.14", 1'b1, 16'h0000, 4'd14);
    step();
    chk_out("wr.15", 1'b1, 16'h1234, 4'd15);
    step();
    chk_out("wr.0", 1'b1, 16'h40A0, 4'd0);
    step();
    chk_out("wr.1", 1'b1, 16'h6000, 4'd1);

    // Reset while the skid is full
    stall = 1'b1;
    step();
    chk_out("rh.hold", 1'b1, 16'h6000, 4'd1);
    rst_n = 1'b0;
    step();
    chk("rh.valid", 32'(instr_valid), 32'd0);
    chk("rh.instr", 32'(instr), 32'd0);
    chk("rh.pc", 32'(instr_pc), 32'd0);
    chk("rh.addr", 32'(imem.addr), 32'd0);
    rst_n = 1'b1;
    stall = 1'b0;
    step();
    chk_out("rh.e1", 1'b0, 16'h0, 4'd0);
    step();
    chk_out("rh.0", 1'b1, 16'h40A0, 4'd0);
    step();
    chk_out("rh.1", 1'b1, 16'h6000, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
